// File: rtl/small_tone_detect.sv
// small_tone_detect
//
// Purpose:
//   Tone-presence detector placed after a bandpass filter. Each sample
//   strobe takes the saturated magnitude of the filter output and feeds it
//   into a leaky integrator. The integrator output is the smoothed
//   envelope. A four-state FSM (IDLE / ATTACK / ACTIVE / RELEASE) requires
//   HOLD_COUNT consecutive qualifying samples before it changes the detect
//   flag. This debounces the flag against short bursts and dropouts.
//
// Parameters:
//   WIDTH       - sample width of dataIn and envelope
//   SHIFT_DECAY - integrator leak shift (time constant of about 2^SHIFT_DECAY samples)
//   HOLD_COUNT  - consecutive qualifying samples needed to change detect
//
// Ports:
//   clk         - system clock, rising-edge active
//   rst         - asynchronous reset, active-low
//   en          - sample strobe, aligned with the bandpass filter's enable
//   dataIn      - signed bandpass filter output sample
//   thresholdHi - unsigned attack threshold
//   thresholdLo - unsigned release threshold (used only with hysteresis)
//   envelope    - registered smoothed magnitude
//   detect      - registered tone-present flag
//   detectEdge  - one-cycle pulse on every change of detect
//
// Configuration macro:
//   SMALL_TONE_DETECT_HYST_EN - when defined, the release threshold is
//   thresholdLo, which gives hysteresis. When undefined, the release
//   threshold is thresholdHi and thresholdLo is ignored.

module small_tone_detect #(
    parameter int WIDTH       = 16,
    parameter int SHIFT_DECAY = 8,
    parameter int HOLD_COUNT  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] dataIn,
    input  logic        [WIDTH-1:0] thresholdHi,
    input  logic        [WIDTH-1:0] thresholdLo,
    output logic        [WIDTH-1:0] envelope,
    output logic                    detect,
    output logic                    detectEdge
);

    localparam int ACC_W = WIDTH + SHIFT_DECAY;
    localparam int CNT_W = $clog2(HOLD_COUNT + 1);
    localparam logic [CNT_W-1:0] HOLD = CNT_W'(HOLD_COUNT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        ACTIVE  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t             state, stateNext;
    logic [CNT_W-1:0]   cnt, cntNext, cntInc;
    logic               detectNext, edgeNext;

    logic [WIDTH-1:0]   dataU, negData;
    logic [WIDTH-2:0]   mag;
    logic [ACC_W-1:0]   acc, accNext, leak;
    logic [WIDTH-1:0]   relTh;

    // Release threshold selection. Without hysteresis the release
    // threshold is the attack threshold, so thresholdLo has no effect.
`ifdef SMALL_TONE_DETECT_HYST_EN
    assign relTh = thresholdLo;
`else
    logic unusedLo;
    assign relTh    = thresholdHi;
    assign unusedLo = ^thresholdLo;
`endif

    // Saturating magnitude. The most negative input has no positive
    // counterpart in WIDTH-1 bits, so it is clamped to the largest magnitude.
    assign dataU   = dataIn;
    assign negData = ~dataU + {{(WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        mag = '0;
        if (dataU[WIDTH-1]) begin
            if (dataU == {1'b1, {(WIDTH-1){1'b0}}})
                mag = '1;
            else
                mag = negData[WIDTH-2:0];
        end else begin
            mag = dataU[WIDTH-2:0];
        end
    end

    // Leaky integrator update. The integrator settles at about
    // mag << SHIFT_DECAY, bounded below 2^(WIDTH-1+SHIFT_DECAY).
    // Because of that bound, neither acc+mag nor the result can wrap
    // in ACC_W bits.
    assign leak    = acc >> SHIFT_DECAY;
    assign accNext = acc + {{(SHIFT_DECAY+1){1'b0}}, mag} - leak;

    // Integrator and envelope registers. The envelope is sampled from the
    // pre-edge accumulator, so it trails acc by one sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc      <= '0;
            envelope <= '0;
        end else if (en) begin
            acc      <= accNext;
            envelope <= acc[ACC_W-1:SHIFT_DECAY];
        end
    end

    // FSM state, hold counter, and output flags. detectEdge is reloaded
    // every cycle, so it reads 0 on any cycle without a strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            detect     <= 1'b0;
            detectEdge <= 1'b0;
        end else begin
            state      <= stateNext;
            cnt        <= cntNext;
            detect     <= detectNext;
            detectEdge <= edgeNext;
        end
    end

    assign cntInc = cnt + {{(CNT_W-1){1'b0}}, 1'b1};

    // Next-state logic. It compares the registered (pre-edge) envelope
    // against the thresholds. ATTACK and RELEASE count consecutive
    // qualifying samples. A single non-qualifying sample sends the FSM
    // back to the settled state with the count cleared. With HOLD_COUNT of
    // 1, the first qualifying sample changes detect directly and skips
    // the counting states.
    always_comb begin
        stateNext  = state;
        cntNext    = cnt;
        detectNext = detect;
        edgeNext   = 1'b0;
        if (en) begin
            case (state)
                IDLE: begin
                    if (envelope >= thresholdHi) begin
                        if (HOLD_COUNT <= 1) begin
                            stateNext  = ACTIVE;
                            cntNext    = '0;
                            detectNext = 1'b1;
                            edgeNext   = 1'b1;
                        end else begin
                            stateNext = ATTACK;
                            cntNext   = {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                ATTACK: begin
                    if (envelope < thresholdHi) begin
                        stateNext = IDLE;
                        cntNext   = '0;
                    end else if (cntInc >= HOLD) begin
                        stateNext  = ACTIVE;
                        cntNext    = '0;
                        detectNext = 1'b1;
                        edgeNext   = 1'b1;
                    end else begin
                        cntNext = cntInc;
                    end
                end
                ACTIVE: begin
                    if (envelope < relTh) begin
                        if (HOLD_COUNT <= 1) begin
                            stateNext  = IDLE;
                            cntNext    = '0;
                            detectNext = 1'b0;
                            edgeNext   = 1'b1;
                        end else begin
                            stateNext = RELEASE;
                            cntNext   = {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                RELEASE: begin
                    if (envelope >= relTh) begin
                        stateNext = ACTIVE;
                        cntNext   = '0;
                    end else if (cntInc >= HOLD) begin
                        stateNext  = IDLE;
                        cntNext    = '0;
                        detectNext = 1'b0;
                        edgeNext   = 1'b1;
                    end else begin
                        cntNext = cntInc;
                    end
                end
                default: begin
                    stateNext  = IDLE;
                    cntNext    = '0;
                    detectNext = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_small_tone_detect.sv
// tb_small_tone_detect
//
// Purpose:
//   Directed bench for small_tone_detect. Two instances share one set of
//   inputs: one with HOLD_COUNT=4 and one with HOLD_COUNT=1. A reference
//   model computes the expected outputs of both instances whenever
//   stimulus is driven. The bench pushes those expectations to a
//   scoreboard queue and pops them after the clock edge. The release
//   threshold in the model follows SMALL_TONE_DETECT_HYST_EN, so the
//   bench builds with or without hysteresis.
//
// Ports: none (top-level bench).

module tb_small_tone_detect;

    localparam int W  = 16;
    localparam int SD = 4;
    localparam int HC = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               en  = 1'b0;
    logic signed [W-1:0] dataIn = '0;
    logic [W-1:0]       thHi = '0;
    logic [W-1:0]       thLo = '0;
    logic [W-1:0]       env0, env1;
    logic               det0, det1, edg0, edg1;

    small_tone_detect #(.WIDTH(W), .SHIFT_DECAY(SD), .HOLD_COUNT(HC)) dut0 (
        .clk(clk), .rst(rst), .en(en), .dataIn(dataIn),
        .thresholdHi(thHi), .thresholdLo(thLo),
        .envelope(env0), .detect(det0), .detectEdge(edg0)
    );

    small_tone_detect #(.WIDTH(W), .SHIFT_DECAY(SD), .HOLD_COUNT(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .dataIn(dataIn),
        .thresholdHi(thHi), .thresholdLo(thLo),
        .envelope(env1), .detect(det1), .detectEdge(edg1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    env0;
        int    env1;
        bit    det0;
        bit    det1;
        bit    edg0;
        bit    edg1;
        string tag;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // Reference model state: an integrator, the envelope, the detect flag,
    // and a run length of consecutive qualifying samples per instance.
    int macc[2];
    int menv[2];
    int mrun[2];
    bit mdet[2];
    bit medg[2];
    int holdOf[2];

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string name);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    task automatic resetModel();
        for (int i = 0; i < 2; i++) begin
            macc[i] = 0;
            menv[i] = 0;
            mrun[i] = 0;
            mdet[i] = 1'b0;
            medg[i] = 1'b0;
        end
    endtask

    task automatic modelStep(input bit e, input int d, input int hi, input int lo);
        int rel;
        int mag;
        bit qual;
`ifdef SMALL_TONE_DETECT_HYST_EN
        rel = lo;
`else
        rel = hi;
`endif
        mag = (d < 0) ? ((d == -32768) ? 32767 : -d) : d;
        for (int i = 0; i < 2; i++) begin
            medg[i] = 1'b0;
            if (e) begin
                qual = mdet[i] ? (menv[i] < rel) : (menv[i] >= hi);
                mrun[i] = qual ? mrun[i] + 1 : 0;
                if (mrun[i] == holdOf[i]) begin
                    mdet[i] = ~mdet[i];
                    medg[i] = 1'b1;
                    mrun[i] = 0;
                end
                menv[i] = macc[i] >> SD;
                macc[i] = macc[i] + mag - (macc[i] >> SD);
            end
        end
    endtask

    // Drive one sample on the falling edge and queue the model's
    // prediction for the following rising edge.
    task automatic applyStimulus(input bit e, input int d, input int hi, input int lo, input string tag);
        exp_t x;
        @(negedge clk);
        en     = e;
        dataIn = W'(d);
        thHi   = W'(hi);
        thLo   = W'(lo);
        modelStep(e, d, hi, lo);
        x.env0 = menv[0];
        x.env1 = menv[1];
        x.det0 = mdet[0];
        x.det1 = mdet[1];
        x.edg0 = medg[0];
        x.edg1 = medg[1];
        x.tag  = tag;
        sb.push_back(x);
    endtask

    task automatic checkOutput();
        exp_t x;
        @(posedge clk);
        #1;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("[TB] FAIL sbUnderflow observed=0 expected=1");
            return;
        end
        x = sb.pop_front();
        chk(32'(env0), x.env0, {x.tag, ".env0"});
        chk(32'(det0), 32'(x.det0), {x.tag, ".det0"});
        chk(32'(edg0), 32'(x.edg0), {x.tag, ".edge0"});
        chk(32'(env1), x.env1, {x.tag, ".env1"});
        chk(32'(det1), 32'(x.det1), {x.tag, ".det1"});
        chk(32'(edg1), 32'(x.edg1), {x.tag, ".edge1"});
    endtask

    task automatic step(input bit e, input int d, input int hi, input int lo, input string tag);
        applyStimulus(e, d, hi, lo, tag);
        checkOutput();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        holdOf[0] = HC;
        holdOf[1] = 1;
        resetModel();

        // Reset state while rst is held low.
        #2;
        chk(32'(env0), 0, "reset.env0");
        chk(32'(det0), 0, "reset.det0");
        chk(32'(edg0), 0, "reset.edge0");
        chk(32'(det1), 0, "reset.det1");
        @(negedge clk);
        rst = 1'b1;

        // Constant tone of 1000: the envelope settles and detect rises.
        for (int i = 0; i < 200; i++) step(1'b1, 1000, 900, 500, "tone1000");
        chk(32'(env0), 1000, "settle1000");
        chk(32'(det0), 1, "detectOn1000");

        // Tone removed. Detect holds until the release count completes.
        // A single loud sample early in the count returns the FSM to ACTIVE.
        n = 0;
        while (menv[0] >= 500 && n < 100) begin
            step(1'b1, 0, 900, 500, "decay");
            n++;
        end
        chk(32'(n < 100), 1, "decayBound");
        step(1'b1, 16000, 900, 500, "bump");
        n = 0;
        while (mdet[0] && n < 200) begin
            step(1'b1, 0, 900, 500, "release");
            n++;
        end
        chk(32'(n < 200), 1, "releaseBound");
        chk(32'(det0), 0, "detectOffAfterRelease");

        // Full-scale negative input saturates the magnitude without wrapping.
        for (int i = 0; i < 250; i++) step(1'b1, -32768, 900, 500, "fullscale");
        chk(32'(env0), 32767, "settle32767");
        chk(32'(det0), 1, "detectOnFullscale");

        // Decay into RELEASE with a count of 2, then reset asynchronously
        // mid-cycle.
        n = 0;
        while (!(mdet[0] && mrun[0] == 2) && n < 300) begin
            step(1'b1, 0, 900, 500, "toRelease");
            n++;
        end
        chk(32'(n < 300), 1, "releaseCnt2Bound");
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk(32'(env0), 0, "asyncRst.env0");
        chk(32'(det0), 0, "asyncRst.det0");
        chk(32'(edg0), 0, "asyncRst.edge0");
        chk(32'(env1), 0, "asyncRst.env1");
        chk(32'(det1), 0, "asyncRst.det1");
        resetModel();
        @(negedge clk);
        rst = 1'b1;

        // Sample strobe on one cycle in three. Outputs freeze between strobes.
        for (int i = 0; i < 120; i++)
            step((i % 3) == 0, 1000, 900, 500, "strobe1in3");

        // Release threshold above the attack threshold. The transitions
        // still follow the literal rules.
        for (int i = 0; i < 60; i++) step(1'b1, 1000, 900, 2000, "loAboveHi");

        // Random samples and thresholds that change every cycle.
        for (int i = 0; i < 60; i++)
            step(1'b1, int'($urandom_range(0, 4000)) - 2000,
                 int'($urandom_range(0, 1500)), int'($urandom_range(0, 1500)), "random");

        chk(32'(sb.size()), 0, "sbEmpty");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
